// File: rtl/axi_reg_pkg.sv
// Shared types for the AXI to register-bank bridge.
// FSM states, AXI response codes and bank index sizing.
package axi_reg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_STROBE,
        RD_RESP,
        WR_STROBE,
        WR_RESP
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_ifc.sv
// Single-beat AXI port used by the register-bank bridge.
// Burst fields are omitted: masters issue single 32-bit beats only.
interface axi_ifc #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32
);

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;

    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;

    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport slave (
        input  arid, araddr, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_reg_bank_mux.sv
// Selects one bank's read data and acknowledges by index.
// bad is high when the index names no existing bank.
module axi_reg_bank_mux #(
    parameter int COUNT = 8,
    parameter int BW    = 3
) (
    input  logic [BW-1:0]       idx,
    input  logic [COUNT*32-1:0] rdata_all,
    input  logic [COUNT-1:0]    rack_all,
    input  logic [COUNT-1:0]    wack_all,
    output logic [31:0]         rdata,
    output logic                rack,
    output logic                wack,
    output logic                bad
);

    always_comb begin
        rdata = '0;
        rack  = 1'b0;
        wack  = 1'b0;
        bad   = 1'b1;
        for (int b = 0; b < COUNT; b++) begin
            if (idx == BW'(b)) begin
                rdata = rdata_all[32*b +: 32];
                rack  = rack_all[b];
                wack  = wack_all[b];
                bad   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/axi_to_reg_banks.sv
// AXI slave bridging single-beat accesses onto COUNT register banks.
// One transaction in flight; read/write priority toggles per grant.
module axi_to_reg_banks
    import axi_reg_pkg::*;
#(
    parameter int COUNT        = 8,
    parameter int R_ADDR_WIDTH = 20,
    parameter int TIMEOUT      = 16,
    parameter int ID_W         = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    axi_ifc.slave                   axi,
    output logic [COUNT-1:0]        o_rd,
    output logic [COUNT-1:0]        o_wr,
    output logic [R_ADDR_WIDTH-1:0] o_raddr,
    output logic [R_ADDR_WIDTH-1:0] o_waddr,
    output logic [31:0]             o_wdata,
    input  logic [COUNT*32-1:0]     i_rdata,
    input  logic [COUNT-1:0]        i_rack,
    input  logic [COUNT-1:0]        i_wack
);

    localparam int BW = idx_bits(COUNT);
    localparam logic [COUNT-1:0] ONE = 1;

    state_t            state;
    logic              prio_wr;
    logic [7:0]        cnt;
    logic [BW-1:0]     bank;
    logic [ID_W-1:0]   rid_q;
    logic [ID_W-1:0]   bid_q;
    logic [31:0]       rdata_q;
    logic [1:0]        rresp_q;
    logic [1:0]        bresp_q;
    logic              rvalid_q;
    logic              bvalid_q;

    logic              rd_c;
    logic              wr_c;
    logic              rd_go;
    logic              wr_go;
    logic              timed_out;
    logic [BW-1:0]     ar_bank;
    logic [BW-1:0]     aw_bank;
    logic [BW-1:0]     sel;
    logic [31:0]       m_rdata;
    logic              m_rack;
    logic              m_wack;
    logic              m_bad;

    assign ar_bank   = axi.araddr[R_ADDR_WIDTH +: BW];
    assign aw_bank   = axi.awaddr[R_ADDR_WIDTH +: BW];
    assign timed_out = (cnt == 8'(TIMEOUT - 1));

    // Ready is combinational so the grant costs no extra cycle.
    always_comb begin
        rd_c  = axi.arvalid;
        wr_c  = axi.awvalid & axi.wvalid;
        rd_go = (state == IDLE) && !reset && rd_c
              && (!wr_c || !prio_wr);
        wr_go = (state == IDLE) && !reset && wr_c
              && (!rd_c || prio_wr);
        if (state == IDLE)
            sel = rd_go ? ar_bank : aw_bank;
        else
            sel = bank;
    end

    axi_reg_bank_mux #(
        .COUNT (COUNT),
        .BW    (BW)
    ) u_mux (
        .idx       (sel),
        .rdata_all (i_rdata),
        .rack_all  (i_rack),
        .wack_all  (i_wack),
        .rdata     (m_rdata),
        .rack      (m_rack),
        .wack      (m_wack),
        .bad       (m_bad)
    );

    assign axi.arready = rd_go;
    assign axi.awready = wr_go;
    assign axi.wready  = wr_go;
    assign axi.rid     = rid_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;
    assign axi.rlast   = rvalid_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.bid     = bid_q;
    assign axi.bresp   = bresp_q;
    assign axi.bvalid  = bvalid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            prio_wr  <= 1'b0;
            cnt      <= '0;
            bank     <= '0;
            rid_q    <= '0;
            bid_q    <= '0;
            rdata_q  <= '0;
            rresp_q  <= OKAY;
            bresp_q  <= OKAY;
            rvalid_q <= 1'b0;
            bvalid_q <= 1'b0;
            o_rd     <= '0;
            o_wr     <= '0;
            o_raddr  <= '0;
            o_waddr  <= '0;
            o_wdata  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rd_go) begin
                        prio_wr <= ~prio_wr;
                        rid_q   <= axi.arid;
                        bank    <= ar_bank;
                        if (m_bad) begin
                            rresp_q  <= DECERR;
                            rdata_q  <= '0;
                            rvalid_q <= 1'b1;
                            state    <= RD_RESP;
                        end else begin
                            o_rd    <= ONE << ar_bank;
                            o_raddr <= axi.araddr[R_ADDR_WIDTH-1:0];
                            state   <= RD_STROBE;
                        end
                    end else if (wr_go) begin
                        prio_wr <= ~prio_wr;
                        bid_q   <= axi.awid;
                        bank    <= aw_bank;
                        if (m_bad) begin
                            bresp_q  <= DECERR;
                            bvalid_q <= 1'b1;
                            state    <= WR_RESP;
                        end else if (axi.wstrb != 4'hF) begin
                            bresp_q  <= SLVERR;
                            bvalid_q <= 1'b1;
                            state    <= WR_RESP;
                        end else begin
                            o_wr    <= ONE << aw_bank;
                            o_waddr <= axi.awaddr[R_ADDR_WIDTH-1:0];
                            o_wdata <= axi.wdata;
                            state   <= WR_STROBE;
                        end
                    end
                end
                // Ack wins over a timeout landing in the same cycle.
                RD_STROBE: begin
                    if (m_rack) begin
                        o_rd     <= '0;
                        rdata_q  <= m_rdata;
                        rresp_q  <= OKAY;
                        rvalid_q <= 1'b1;
                        state    <= RD_RESP;
                    end else if (timed_out) begin
                        o_rd     <= '0;
                        rdata_q  <= '0;
                        rresp_q  <= SLVERR;
                        rvalid_q <= 1'b1;
                        state    <= RD_RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RD_RESP: begin
                    if (axi.rready) begin
                        rvalid_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                WR_STROBE: begin
                    if (m_wack) begin
                        o_wr     <= '0;
                        bresp_q  <= OKAY;
                        bvalid_q <= 1'b1;
                        state    <= WR_RESP;
                    end else if (timed_out) begin
                        o_wr     <= '0;
                        bresp_q  <= SLVERR;
                        bvalid_q <= 1'b1;
                        state    <= WR_RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WR_RESP: begin
                    if (axi.bready) begin
                        bvalid_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_to_reg_banks.sv
// Bench for axi_to_reg_banks: directed table, contested pairs,
// random traffic against a response/latency model, reset abort.
module tb_axi_to_reg_banks;
    import axi_reg_pkg::*;

    localparam int COUNT = 6;
    localparam int RAW   = 20;
    localparam int TMO   = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    axi_ifc #(.ID_W(4), .ADDR_W(32)) axi ();

    logic [COUNT-1:0]    o_rd;
    logic [COUNT-1:0]    o_wr;
    logic [RAW-1:0]      o_raddr;
    logic [RAW-1:0]      o_waddr;
    logic [31:0]         o_wdata;
    logic [COUNT*32-1:0] i_rdata;
    logic [COUNT-1:0]    i_rack;
    logic [COUNT-1:0]    i_wack;

    axi_to_reg_banks #(
        .COUNT        (COUNT),
        .R_ADDR_WIDTH (RAW),
        .TIMEOUT      (TMO),
        .ID_W         (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .axi     (axi),
        .o_rd    (o_rd),
        .o_wr    (o_wr),
        .o_raddr (o_raddr),
        .o_waddr (o_waddr),
        .o_wdata (o_wdata),
        .i_rdata (i_rdata),
        .i_rack  (i_rack),
        .i_wack  (i_wack)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          dly;
        logic [1:0]  eresp;
        int          ecyc;
    } vec_t;

    typedef struct {
        logic [1:0]       resp;
        logic [31:0]      data;
        logic [3:0]       id;
        logic             last;
        int               lat;
        int               scyc;
        logic [COUNT-1:0] mask;
        logic [RAW-1:0]   addr;
        logic [31:0]      wdata;
        int               gcyc;
    } obs_t;

    // Bank models: delay 0 means ack tied high, else ack after dly cycles.
    logic [31:0] bank_rd [COUNT];
    int rdly [COUNT];
    int wdly [COUNT];
    int rcnt [COUNT] = '{default: 0};
    int wcnt [COUNT] = '{default: 0};
    int cyc = 0;
    int ncmp = 0;
    int nbad = 0;
    bit mprio_wr = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int b = 0; b < COUNT; b++) begin
            rcnt[b] <= o_rd[b] ? rcnt[b] + 1 : 0;
            wcnt[b] <= o_wr[b] ? wcnt[b] + 1 : 0;
        end
    end

    always_comb begin
        i_rack  = '0;
        i_wack  = '0;
        i_rdata = '0;
        for (int b = 0; b < COUNT; b++) begin
            i_rack[b] = (rdly[b] == 0) || (o_rd[b] && rcnt[b] >= rdly[b]);
            i_wack[b] = (wdly[b] == 0) || (o_wr[b] && wcnt[b] >= wdly[b]);
            i_rdata[32*b +: 32] = bank_rd[b];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_rst(input string t);
        chk({t, "_strobes"}, {o_rd, o_wr}, 0);
        chk({t, "_addrs"}, {o_raddr, o_waddr}, 0);
        chk({t, "_wdata"}, o_wdata, 0);
        chk({t, "_valids"}, {axi.arready, axi.awready, axi.wready,
                             axi.rvalid, axi.bvalid}, 0);
        chk({t, "_rfields"}, {axi.rresp, axi.rdata, axi.rid}, 0);
        chk({t, "_bfields"}, {axi.bresp, axi.bid}, 0);
    endtask

    // Outcome derived from the bank's behaviour, not from FSM internals.
    task automatic model(input vec_t v, output logic [1:0] r, output int c);
        int bk;
        bk = int'(v.addr[RAW +: 3]);
        if (bk >= COUNT) begin
            r = DECERR; c = 0;
        end else if (v.wr && v.strb != 4'hF) begin
            r = SLVERR; c = 0;
        end else if (v.dly >= TMO) begin
            r = SLVERR; c = TMO;
        end else begin
            r = OKAY; c = v.dly + 1;
        end
    endtask

    task automatic run_txn(input vec_t v, input logic [3:0] id,
                           output obs_t o);
        int bk;
        int n;
        logic hs;
        logic [COUNT-1:0] s;
        o = '{default: '0};
        bk = int'(v.addr[RAW +: 3]);
        if (bk < COUNT) begin
            if (v.wr) wdly[bk] = v.dly;
            else begin
                rdly[bk] = v.dly;
                bank_rd[bk] = v.data;
            end
        end
        @(negedge clk);
        if (v.wr) begin
            axi.awvalid = 1'b1; axi.wvalid = 1'b1;
            axi.awaddr = v.addr; axi.awid = id;
            axi.wdata = v.data; axi.wstrb = v.strb;
        end else begin
            axi.arvalid = 1'b1; axi.araddr = v.addr; axi.arid = id;
        end
        #1;
        n = 0;
        hs = v.wr ? axi.awready : axi.arready;
        while (!hs && n < 200) begin
            @(negedge clk); #1;
            n++;
            hs = v.wr ? axi.awready : axi.arready;
        end
        o.gcyc = cyc;
        @(posedge clk); #1;
        if (v.wr) begin
            axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        end else begin
            axi.arvalid = 1'b0;
        end
        if (!hs) begin
            o.lat = -1;
            return;
        end
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            s = v.wr ? o_wr : o_rd;
            if (s != '0) begin
                o.scyc++;
                o.mask |= s;
                o.addr = v.wr ? o_waddr : o_raddr;
                o.wdata = o_wdata;
            end
            if (v.wr ? axi.bvalid : axi.rvalid) break;
        end
        o.lat = n;
        if (v.wr) begin
            o.resp = axi.bresp; o.id = axi.bid; o.last = 1'b1;
            axi.bready = 1'b1;
        end else begin
            o.resp = axi.rresp; o.data = axi.rdata;
            o.id = axi.rid; o.last = axi.rlast;
            axi.rready = 1'b1;
        end
        @(posedge clk); #1;
        axi.bready = 1'b0;
        axi.rready = 1'b0;
        if (bk < COUNT) begin
            if (v.wr) wdly[bk] = 0;
            else rdly[bk] = 0;
        end
    endtask

    task automatic check_txn(input string t, input vec_t v,
                             input logic [3:0] id, input obs_t o,
                             input logic [1:0] er, input int ec);
        int bk;
        logic [COUNT-1:0] em;
        bk = int'(v.addr[RAW +: 3]);
        em = (ec > 0) ? (COUNT'(1) << bk) : '0;
        chk({t, "_resp"}, o.resp, er);
        chk({t, "_id"}, o.id, id);
        chk({t, "_strobe_cycles"}, o.scyc, ec);
        chk({t, "_latency"}, o.lat, ec + 1);
        chk({t, "_strobe_mask"}, o.mask, em);
        if (!v.wr) begin
            chk({t, "_rdata"}, o.data, (er == OKAY) ? v.data : 32'h0);
            chk({t, "_rlast"}, o.last, 1);
        end
        if (ec > 0) begin
            chk({t, "_regaddr"}, o.addr, v.addr[RAW-1:0]);
            if (v.wr) chk({t, "_wdata"}, o.wdata, v.data);
        end
    endtask

    task automatic run_one(input string t, input vec_t v,
                           input logic [3:0] id, input logic [1:0] er,
                           input int ec, output obs_t o);
        run_txn(v, id, o);
        check_txn(t, v, id, o, er, ec);
        mprio_wr = !mprio_wr;
    endtask

    task automatic run_pair(input string t, input vec_t vr, input vec_t vw);
        obs_t orr;
        obs_t ow;
        logic [1:0] er;
        int ec;
        bit wfirst;
        wfirst = mprio_wr;
        fork
            run_txn(vr, 4'h5, orr);
            run_txn(vw, 4'hA, ow);
        join
        chk({t, "_write_first"}, (ow.gcyc < orr.gcyc), wfirst);
        model(vr, er, ec);
        check_txn({t, "_rd"}, vr, 4'h5, orr, er, ec);
        model(vw, er, ec);
        check_txn({t, "_wr"}, vw, 4'hA, ow, er, ec);
    endtask

    function automatic vec_t rnd_vec();
        vec_t v;
        int dl [7] = '{0, 1, 2, 3, 15, 16, 255};
        logic [2:0] bk;
        bk = 3'($urandom_range(0, 7));
        v.wr = 1'($urandom_range(0, 1));
        v.addr = {9'h0, bk, 20'($urandom)};
        v.data = $urandom;
        v.strb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        v.dly = dl[$urandom_range(0, 6)];
        v.eresp = OKAY;
        v.ecyc = 0;
        return v;
    endfunction

    vec_t tv [11];

    initial begin
        vec_t v;
        vec_t w;
        obs_t o;
        obs_t o1;
        obs_t o2;
        int n;
        int seen;

        axi.arvalid = 0; axi.arid = 0; axi.araddr = 0;
        axi.awvalid = 0; axi.awid = 0; axi.awaddr = 0;
        axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0;
        axi.rready = 0; axi.bready = 0;
        for (int b = 0; b < COUNT; b++) begin
            rdly[b] = 0; wdly[b] = 0; bank_rd[b] = 32'h0;
        end

        tv[0]  = '{0, 32'h0030_0010, 32'h1234_5678, 4'hF, 0,   OKAY,   1};
        tv[1]  = '{1, 32'h0050_0004, 32'hCAFE_F00D, 4'hF, 4,   OKAY,   5};
        tv[2]  = '{0, 32'h0010_0000, 32'h0BAD_0BAD, 4'hF, 255, SLVERR, 16};
        tv[3]  = '{0, 32'h0020_0008, 32'hA5A5_0001, 4'hF, 0,   OKAY,   1};
        tv[4]  = '{0, 32'h0070_0000, 32'h7777_7777, 4'hF, 0,   DECERR, 0};
        tv[5]  = '{1, 32'h0070_0000, 32'h7777_7777, 4'hF, 0,   DECERR, 0};
        tv[6]  = '{1, 32'h0020_0000, 32'h0000_FFFF, 4'h3, 0,   SLVERR, 0};
        tv[7]  = '{0, 32'h0040_0000, 32'h4444_0015, 4'hF, 15,  OKAY,   16};
        tv[8]  = '{1, 32'h0010_0000, 32'h1010_1010, 4'hF, 16,  SLVERR, 16};
        tv[9]  = '{0, 32'h0060_0000, 32'h6666_6666, 4'hF, 0,   DECERR, 0};
        tv[10] = '{1, 32'h0000_0FFC, 32'h0FFC_0FFC, 4'hF, 2,   OKAY,   3};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_rst("reset");
        reset = 1'b0;

        v = '{0, 32'h0010_0100, 32'h1111_2222, 4'hF, 0, OKAY, 1};
        w = '{1, 32'h0020_0200, 32'h3333_4444, 4'hF, 0, OKAY, 1};
        run_pair("arb1", v, w);

        v = '{0, 32'h0030_0010, 32'h1234_5678, 4'hF, 0, OKAY, 1};
        run_one("solo", v, 4'h2, OKAY, 1, o);

        v = '{0, 32'h0040_0044, 32'h4040_4040, 4'hF, 0, OKAY, 1};
        w = '{1, 32'h0020_0000, 32'hDEAD_BEEF, 4'h3, 0, SLVERR, 0};
        run_pair("arb2", v, w);

        v = '{0, 32'h0000_0010, 32'h0A0A_0A0A, 4'hF, 0, OKAY, 1};
        run_one("tp_a", v, 4'h1, OKAY, 1, o1);
        v = '{0, 32'h0010_0020, 32'h0B0B_0B0B, 4'hF, 0, OKAY, 1};
        run_one("tp_b", v, 4'h3, OKAY, 1, o2);
        chk("throughput", o2.gcyc - o1.gcyc, 3);

        for (int i = 0; i < 11; i++)
            run_one($sformatf("vec%0d", i), tv[i], 4'(i),
                    tv[i].eresp, tv[i].ecyc, o);

        for (int k = 0; k < 40; k++) begin
            logic [1:0] er;
            int ec;
            v = rnd_vec();
            if (k % 8 == 7) begin
                v.wr = 1'b0;
                w = rnd_vec();
                w.wr = 1'b1;
                run_pair($sformatf("rpair%0d", k), v, w);
            end else begin
                model(v, er, ec);
                run_one($sformatf("rnd%0d", k), v, 4'(k), er, ec, o);
            end
        end

        wdly[2] = 255;
        @(negedge clk);
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        axi.awaddr = 32'h0020_0040; axi.awid = 4'h3;
        axi.wdata = 32'h5555_AAAA; axi.wstrb = 4'hF;
        #1;
        n = 0;
        while (!axi.awready && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_owr_held", o_wr, 6'b000100);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_rst("abort");
        reset = 1'b0;
        mprio_wr = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (axi.bvalid) seen++;
        end
        chk("abort_no_bvalid", seen, 0);
        wdly[2] = 0;

        v = '{0, 32'h0020_0030, 32'h2468_ACE0, 4'hF, 1, OKAY, 2};
        run_one("post_abort", v, 4'h9, OKAY, 2, o);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
